// File: rtl/ps2_byte_rx.sv
// PS/2 keyboard frame receiver.
// Synchronises and glitch-filters the raw PS/2 clock and data lines, then
// deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Each good byte appears on dout together with a one-cycle dout_new strobe.
// Rejected frames raise a one-cycle parity_err or frame_err strobe.
module ps2_byte_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       kbd_clk,
    input  logic       kbd_dat,
    output logic [7:0] dout,
    output logic       dout_new,
    output logic       parity_err,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE_ST,
        DATA_ST,
        PARITY_ST,
        STOP_ST
    } state_t;

    // Counter value at which a stalled frame is abandoned.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic                  clk_s;
    logic                  dat_s;
    logic [FILTER_LEN-1:0] filt;
    logic                  clk_f;
    logic                  clk_f_d;
    logic                  fall;

    state_t                state;
    state_t                state_nx;
    logic [2:0]            bitcnt;
    logic [7:0]            shreg;
    logic                  par;
    logic [15:0]           to_cnt;
    logic                  timeout;

    logic                  start_frame;
    logic                  take_bit;
    logic                  latch_par;
    logic                  frame_ok;
    logic                  perr_det;
    logic                  ferr_det;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk or negedge resetN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source, independent of block order.
        if (!resetN) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], kbd_clk};
            dat_sync <= {dat_sync[0], kbd_dat};
        end
    end

    // Glitch filter: clk_f only moves once FILTER_LEN samples agree.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            filt    <= '1;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
        end else begin
            filt    <= {filt[FILTER_LEN-2:0], clk_s};
            clk_f_d <= clk_f;
            if (&filt) begin
                clk_f <= 1'b1;
            end else if (~|filt) begin
                clk_f <= 1'b0;
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    // A stalled frame times out; a coincident falling edge takes precedence.
    assign timeout = (state != IDLE_ST) && (to_cnt == TO_LAST) && !fall;

    // Inter-edge watchdog: restarts on every edge and is held clear while idle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            to_cnt <= '0;
        end else if (fall || state == IDLE_ST) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE_ST;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-edge actions; frame verdict is taken on the stop edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_nx    = state;
        start_frame = 1'b0;
        take_bit    = 1'b0;
        latch_par   = 1'b0;
        frame_ok    = 1'b0;
        perr_det    = 1'b0;
        ferr_det    = 1'b0;

        unique case (state)
            IDLE_ST: begin
                if (fall && !dat_s) begin
                    start_frame = 1'b1;
                    state_nx    = DATA_ST;
                end
            end
            DATA_ST: begin
                if (fall) begin
                    take_bit = 1'b1;
                    if (bitcnt == 3'd7) begin
                        state_nx = PARITY_ST;
                    end
                end
            end
            PARITY_ST: begin
                if (fall) begin
                    latch_par = 1'b1;
                    state_nx  = STOP_ST;
                end
            end
            STOP_ST: begin
                if (fall) begin
                    state_nx = IDLE_ST;
                    if (!dat_s) begin
                        ferr_det = 1'b1;
                    end else if ((^shreg ^ par) == 1'b0) begin
                        perr_det = 1'b1;
                    end else begin
                        frame_ok = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE_ST;
        endcase

        if (timeout) begin
            state_nx = IDLE_ST;
            ferr_det = 1'b1;
        end
    end

    // Deserialiser datapath and registered one-cycle result strobes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bitcnt     <= 3'd0;
            shreg      <= 8'h00;
            par        <= 1'b0;
            dout       <= 8'h00;
            dout_new   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_new   <= frame_ok;
            parity_err <= perr_det;
            frame_err  <= ferr_det;
            if (start_frame) begin
                bitcnt <= 3'd0;
                shreg  <= 8'h00;
            end else if (take_bit) begin
                bitcnt <= bitcnt + 3'd1;
                shreg  <= {dat_s, shreg[7:1]};
            end
            if (latch_par) begin
                par <= dat_s;
            end
            if (frame_ok) begin
                dout <= shreg;
            end
        end
    end

endmodule

// File: doc/ps2_byte_rx.md
# ps2_byte_rx

PS/2 serial frame receiver for the keyboard path. It samples the raw keyboard clock and data lines, filters glitches, and deserialises each 11-bit frame: start bit, 8 data bits LSB first, odd parity, and stop bit. Each valid byte is presented on `dout` with a one-cycle `dout_new` strobe. The output feeds directly into the scan-code sequence recogniser (`din` / `din_new`), which classifies make, break and extended (E0/F0) prefixes.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical synchronised `kbd_clk` samples required to change the filtered clock level.
- `TIMEOUT_CYCLES`, default 50000: maximum number of `clk` cycles allowed between falling edges mid-frame (1 ms at 50 MHz).

- `clk`  in  1  system clock.
- `resetN`  in  1  reset, asynchronous, active-low.
- `kbd_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `kbd_dat`  in  1  raw PS/2 data, asynchronous to `clk`.
- `dout`  out  8  last correctly received byte.
- `dout_new`  out  1  one-cycle strobe: `dout` has just been updated.
- `parity_err`  out  1  one-cycle strobe: frame rejected because of a parity failure.
- `frame_err`  out  1  one-cycle strobe: frame rejected because of a bad stop bit or a timeout.

## Operation
- **Synchronisers.** `kbd_clk` and `kbd_dat` each pass through a 2-flop synchroniser; both flops reset to 1. The outputs are `clk_s` and `dat_s`.
- **Filter.** `FILTER_LEN`-deep shift register on `clk_s`.
  - `clk_f` goes to 0 when all samples are 0 and to 1 when all samples are 1; otherwise it holds.
  - `clk_f` resets to 1.
- **Edge detect.** `fall` = registered `clk_f` is 1 while the current `clk_f` is 0. `dat_s` is sampled in the `fall` cycle.
- **State machine** (reset state `IDLE_ST`):
  - `IDLE_ST`: on `fall`, if `dat_s` = 0 (start bit), clear `bitcnt` and go to `DATA_ST`. If `dat_s` = 1, ignore the edge.
  - `DATA_ST`: on `fall`, shift right with `shreg[7]` <= `dat_s`, then `bitcnt`++. After the 8th bit (`bitcnt` = 7 on entry), go to `PARITY_ST`.
  - `PARITY_ST`: on `fall`, latch `par` <= `dat_s` and go to `STOP_ST`.
  - `STOP_ST`: on `fall`, evaluate the frame in the priority order below, then go to `IDLE_ST`:
    1. `dat_s` = 0: pulse `frame_err`.
    2. Else if XOR(`shreg`, `par`) = 0: pulse `parity_err`.
    3. Else: `dout` <= `shreg` and pulse `dout_new`.
- **Timeout.** 16-bit counter, cleared on every `fall` and while in `IDLE_ST`, otherwise incrementing.
  - When it reaches `TIMEOUT_CYCLES`-1 in any non-idle state: pulse `frame_err`, go to `IDLE_ST`, discard the partial byte.
  - If a timeout and a `fall` occur in the same cycle, the `fall` wins.
- **Output rules.**
  - `dout` changes only together with `dout_new`; it holds its value across errors.
  - At most one of `dout_new`, `parity_err` and `frame_err` is high in any cycle.
- **Out of scope.** Host-to-device transmission; the block never drives the PS/2 lines.

## Timing
- **Reset values.** `dout` = 0x00, `dout_new` = 0, `parity_err` = 0, `frame_err` = 0, state `IDLE_ST`, `bitcnt` = 0, `clk_f` = 1. Reset asserted mid-frame aborts the frame silently, with no error strobe.
- **Input latency.** A `kbd_clk` falling edge reaches `fall` after 2 (synchroniser) + `FILTER_LEN` + 1 cycles. `kbd_dat` must be stable over that window; the PS/2 timing of roughly 5 µs data setup before the clock edge is guaranteed by the device.
- **Output latency.** `dout_new`, `parity_err` and `frame_err` are asserted the cycle after the stop-bit `fall` and last exactly 1 cycle.
- **Back-to-back frames.** Supported: the next start bit is accepted on any `fall` after returning to `IDLE_ST`.
- **Glitch rejection.** Clock glitches shorter than `FILTER_LEN` cycles produce no edge.

## Test plan
Frames are sent at a 12.5 kHz PS/2 clock with `clk` at 50 MHz.
- **Single byte.** Frame 0x1C, parity 0, stop 1 -> one `dout_new` pulse, `dout` = 0x1C, no error strobes.
- **Extended break sequence.** Back-to-back frames E0 (par 0), F0 (par 1), 74 (par 1) -> three `dout_new` pulses in that order, with `dout` = E0, F0, 74 respectively.
- **Parity error.** Send 0x1C with par 1 after a good 0x5A -> one `parity_err` pulse, no `dout_new`, `dout` stays 0x5A.
- **Stop-bit error.** Send 0x1C with stop = 0 -> one `frame_err` pulse, no `dout_new`; a following good 0x29 (par 0) -> `dout` = 0x29.
- **Glitch and timeout.** While idle, drive a 6-cycle low glitch on `kbd_clk` -> no state change. Then send a start bit plus 4 data bits and stall for 60000 cycles -> `frame_err` pulse at `TIMEOUT_CYCLES`-1 after the last edge; a subsequent good 0x1C is received correctly.
- **Reset mid-frame.** Assert `resetN` = 0 after 5 bits -> all outputs return to reset values with no strobes; a good 0x16 after release -> `dout` = 0x16.
